single_port_ram: RTL and testbench

// - Synchronous single-port RAM, 64 x 8 bit, one shared address for read and write.
// - Generic on-chip storage primitive used by the memory subsystem; infers block/distributed RAM.
// - Registered read with write-through: q always reflects the word at the last sampled address.
//

---
 rtl/single_port_ram_pkg.sv | 11 +
 rtl/single_port_ram.sv | 54 +++++
 tb/tb_single_port_ram.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/single_port_ram_pkg.sv
// Shared defaults and types for the single-port RAM.
package single_port_ram_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 6;
   localparam int DEF_DEPTH      = 64;

   typedef logic [DEF_DATA_WIDTH-1:0] ram_data_t;
   typedef logic [DEF_ADDR_WIDTH-1:0] ram_addr_t;

endpackage : single_port_ram_pkg

// File: rtl/single_port_ram.sv
// Synchronous single-port RAM with a registered read address.
// The read data comes from the array at the address captured on the last
// edge, so a write shows its new data on q right after that edge.
// A reset blanks q to zero without touching the stored words.
module single_port_ram
   import single_port_ram_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  we,
   output logic [DATA_WIDTH-1:0] q
);

   // Every address must map onto a real word.
   if (DEPTH != 2 ** ADDR_WIDTH) begin : g_depth_check
      $error("single_port_ram: DEPTH must equal 2**ADDR_WIDTH");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic                  rd_valid;

   // Array write port; writes are suppressed while reset is asserted.
   // NOTE: the array has no reset so tools can map it onto RAM macros;
   // clearing it would force a flop-based implementation.
   always_ff @(posedge clk) begin
      if (rst_n && we) begin
         mem[addr] <= data;
      end
   end

   // Capture the read address every non-reset edge; rd_valid gates q after reset.
   // NOTE: non-blocking assignments keep this register and the array write
   // above order-independent within the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_reg <= '0;
         rd_valid <= 1'b0;
      end else begin
         addr_reg <= addr;
         rd_valid <= 1'b1;
      end
   end

   // Read through the registered address; zero until the first post-reset edge.
   assign q = rd_valid ? mem[addr_reg] : '0;

endmodule : single_port_ram

// File: tb/tb_single_port_ram.sv
// Directed self-checking bench for single_port_ram.
module tb_single_port_ram;
   import single_port_ram_pkg::*;

   logic      clk;
   logic      rst_n;
   ram_data_t data;
   ram_addr_t addr;
   logic      we;
   ram_data_t q;

   int total = 0;
   int bad   = 0;

   single_port_ram dut (
      .clk   (clk),
      .rst_n (rst_n),
      .data  (data),
      .addr  (addr),
      .we    (we),
      .q     (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      ram_data_t exp;
      // power-on reset, two edges
      rst_n = 1'b0; we = 1'b0; addr = '0; data = '0;
      step(); step();
      total++;
      if (q !== 8'h00) begin
         bad++; $display("FAIL reset_initial q=%h expected=%h", q, 8'h00);
      end
      // write mem[5] = 0x55
      rst_n = 1'b1; we = 1'b1; addr = 6'd5; data = 8'h55;
      step();
      total++;
      if (q !== 8'h55) begin
         bad++; $display("FAIL reset_prewrite q=%h expected=%h", q, 8'h55);
      end
      // one reset edge with addr=5
      rst_n = 1'b0; we = 1'b0; addr = 6'd5;
      step();
      total++;
      if (q !== 8'h00) begin
         bad++; $display("FAIL reset_q_zero q=%h expected=%h", q, 8'h00);
      end
      // memory retained
      rst_n = 1'b1;
      step();
      exp = 8'h55;
      total++;
      if (q !== exp) begin
         bad++; $display("FAIL reset_retain q=%h expected=%h", q, exp);
      end
   endtask

   task automatic test_seq_write();
      for (int i = 0; i < 5; i++) begin
         we = 1'b1; addr = ram_addr_t'(i); data = ram_data_t'(i);
         step();
         total++;
         if (q !== ram_data_t'(i)) begin
            bad++; $display("FAIL seq_write[%0d] q=%h expected=%h", i, q, ram_data_t'(i));
         end
      end
   endtask

   task automatic test_seq_read();
      we = 1'b0; data = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         addr = ram_addr_t'(i);
         step();
         total++;
         if (q !== ram_data_t'(i)) begin
            bad++; $display("FAIL seq_read[%0d] q=%h expected=%h", i, q, ram_data_t'(i));
         end
      end
   endtask

   task automatic test_overwrite();
      we = 1'b1; addr = 6'd63; data = 8'hA5;
      step();
      total++;
      if (q !== 8'hA5) begin
         bad++; $display("FAIL overwrite_first q=%h expected=%h", q, 8'hA5);
      end
      data = 8'h5A;
      step();
      total++;
      if (q !== 8'h5A) begin
         bad++; $display("FAIL overwrite_second q=%h expected=%h", q, 8'h5A);
      end
      // move away then read 63 back
      we = 1'b0; addr = 6'd0;
      step();
      addr = 6'd63;
      step();
      total++;
      if (q !== 8'h5A) begin
         bad++; $display("FAIL overwrite_read q=%h expected=%h", q, 8'h5A);
      end
   endtask

   task automatic test_write_through();
      we = 1'b1; addr = 6'd10; data = 8'hFF;
      step();
      total++;
      if (q !== 8'hFF) begin
         bad++; $display("FAIL write_through q=%h expected=%h", q, 8'hFF);
      end
      // mid-cycle changes must not disturb q
      we = 1'b0; addr = 6'd2; data = 8'h00;
      #3;
      total++;
      if (q !== 8'hFF) begin
         bad++; $display("FAIL midcycle_stable q=%h expected=%h", q, 8'hFF);
      end
      step();
      total++;
      if (q !== 8'h02) begin
         bad++; $display("FAIL after_midcycle q=%h expected=%h", q, 8'h02);
      end
   endtask

   task automatic test_back_to_back();
      // consecutive writes to scattered addresses, then read all back
      we = 1'b1;
      addr = 6'd20; data = 8'h3C; step();
      addr = 6'd41; data = 8'hC3; step();
      addr = 6'd33; data = 8'h81; step();
      we = 1'b0;
      addr = 6'd20; step();
      total++;
      if (q !== 8'h3C) begin
         bad++; $display("FAIL b2b_20 q=%h expected=%h", q, 8'h3C);
      end
      addr = 6'd41; step();
      total++;
      if (q !== 8'hC3) begin
         bad++; $display("FAIL b2b_41 q=%h expected=%h", q, 8'hC3);
      end
      addr = 6'd33; step();
      total++;
      if (q !== 8'h81) begin
         bad++; $display("FAIL b2b_33 q=%h expected=%h", q, 8'h81);
      end
   endtask

   task automatic test_reset_midstream();
      we = 1'b1; addr = 6'd7; data = 8'h17;
      step();
      // reset while a write of 0x77 is presented
      rst_n = 1'b0; data = 8'h77;
      step();
      total++;
      if (q !== 8'h00) begin
         bad++; $display("FAIL midreset_q q=%h expected=%h", q, 8'h00);
      end
      // held reset keeps q at zero
      addr = 6'd63;
      step();
      total++;
      if (q !== 8'h00) begin
         bad++; $display("FAIL midreset_hold q=%h expected=%h", q, 8'h00);
      end
      rst_n = 1'b1; we = 1'b0; addr = 6'd7;
      step();
      total++;
      if (q !== 8'h17) begin
         bad++; $display("FAIL midreset_mem7 q=%h expected=%h", q, 8'h17);
      end
   endtask

   initial begin
      test_reset();
      test_seq_write();
      test_seq_read();
      test_overwrite();
      test_write_through();
      test_back_to_back();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_single_port_ram
